tea_decrypt_core: RTL
=====================

Name: tea_decrypt_core

Overview:
Iterative TEA block-decryption engine. It is the inverse of the team's TEA encryption datapath and consumes ciphertext produced by it.
- Accepts one 64-bit ciphertext block plus a 128-bit key over a valid/ready handshake.
- Runs ROUNDS decryption cycles, each cycle reusing the existing round function F twice.
- Presents the 64-bit plaintext on a valid/ready output port.
- Sits between the link-receive buffer and the payload sink.

Parameters:
ROUNDS, 32, number of TEA cycles; each cycle performs one v1 update and one v0 update.
DELTA, 32'h9E3779B9, TEA key-schedule constant.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  ciphertext block and key are valid.
in_ready  output  1  core can accept a block (high only in IDLE).
in_data  input  64  ciphertext; v0=[63:32], v1=[31:0].
key  input  128  k0=[127:96], k1=[95:64], k2=[63:32], k3=[31:0].
out_valid  output  1  plaintext valid.
out_ready  input  1  sink accepts plaintext.
out_data  output  64  plaintext; v0=[63:32], v1=[31:0].
busy  output  1  high in RUN and DONE.

Behaviour:
- Reset and clocking: one clock; reset is asynchronous and active-low.
- While rst_n is low, all registers clear:
  - state=IDLE, v0=v1=0, sum=0, round counter=0, latched key=0.
  - out_valid=0, out_data=0, busy=0; in_ready=1, since it is decoded from IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE, in_ready=1:
  - On an edge with in_valid=1, latch v0, v1 and key.
  - Load sum = DELTA*ROUNDS mod 2^32 (0xC6EF3720 at the defaults) and clear the counter.
  - Go to RUN.
  - key and in_data may change freely after the accept edge.
- RUN, in_ready=0: each edge performs one cycle, in this order:
  - v1' = v1 - F(v0, k2, k3, sum)
  - v0' = v0 - F(v1', k0, k1, sum)
  - sum' = sum - DELTA
  - counter++
  - F(x, kL, kR, s) = ((x<<4)+kL) ^ (x+s) ^ ((x>>5)+kR), with logical shifts.
  - All arithmetic is mod 2^32 with unsigned wrap and no saturation; the two F evaluations are chained combinationally in one cycle.
  - On the edge completing round ROUNDS (counter==ROUNDS-1), register out_data={v0',v1'}, set out_valid=1 and go to DONE.
- Latency: accept edge = edge 0; out_valid is visible after edge ROUNDS (32 clocks).
- DONE, in_ready=0, out_valid=1:
  - out_data is held stable until an edge with out_ready=1.
  - That edge clears out_valid and returns to IDLE.
  - out_valid never drops without a handshake.
- Throughput: at most one block per ROUNDS+2 cycles; there is no overlap of input and output phases.
- in_valid while not in IDLE is ignored, and nothing is latched.
- Reset asserted mid-RUN or mid-DONE: immediate abort to the reset values; no partial output.
- out_data keeps its last plaintext after the handshake until the next block completes; it is meaningful only while out_valid=1.
- sum reaches 0 after the final round at the defaults. This is checked by assertion, not used as control.

Decomposition:
- Shared header tea_defs.vh:
  - TEA_DELTA = 32'h9E3779B9
  - TEA_ROUNDS = 32
  - TEA_SUM_INIT_DEC = 32'hC6EF3720
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2
- Sub-module: instantiate the existing combinational round function functionF twice, as F_v1 and F_v0. There is no new round logic.
- FSM, counter and registers live in tea_decrypt_core.

Test Plan:
1. Key=0, in_data=64'h41EA3A0A_94BAA940 -> out_data=64'h0 exactly 32 clocks after the accept edge.
2. Round trip: 1000 random keys and plaintexts are encrypted by the bench model, then fed in -> out_data equals the original plaintext every time.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid and out_data stable; in_ready=0 throughout; one handshake then IDLE.
4. Pulse in_valid with a different block at RUN cycle 5 -> ignored; the first block's result is correct; in_ready=0 during RUN.
5. Drop rst_n at RUN cycle 17 -> outputs immediately at reset values; a fresh block after release decrypts correctly.
6. Back-to-back: in_valid and out_ready held high -> blocks accepted every 34 cycles; results in order and correct.

Source files
------------

// File: rtl/tea_decrypt_core_pkg.sv
// Shared TEA constants and the decrypt FSM state encoding.
// No ports; imported by tea_decrypt_core and functionF.
package tea_decrypt_core_pkg;

  localparam logic [31:0] TEA_DELTA        = 32'h9E3779B9;
  localparam int          TEA_ROUNDS       = 32;
  localparam logic [31:0] TEA_SUM_INIT_DEC = 32'hC6EF3720;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tea_decrypt_core_function_f.sv
// TEA round function, purely combinational.
//   x   : 32-bit half-block input
//   kl  : key word added to x<<4
//   kr  : key word added to x>>5
//   s   : running sum
//   f   : ((x<<4)+kl) ^ (x+s) ^ ((x>>5)+kr), all mod 2^32
module functionF
  import tea_decrypt_core_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] kl,
  input  logic [31:0] kr,
  input  logic [31:0] s,
  output logic [31:0] f
);

  assign f = ((x << 4) + kl) ^ (x + s) ^ ((x >> 5) + kr);

endmodule

// File: rtl/tea_decrypt_core.sv
// Iterative TEA block decryption, one cycle (v1 then v0 update) per clock.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : ciphertext + key handshake (ready only in IDLE)
//   in_data, key        : ciphertext {v0,v1} and key {k0,k1,k2,k3}
//   out_valid/out_ready : plaintext handshake, held until accepted
//   out_data            : plaintext {v0,v1}
//   busy                : high in RUN and DONE
//
// state   | meaning
// --------+--------------------------------------------------
// ST_IDLE | waiting for a block, in_ready=1
// ST_RUN  | one TEA cycle per clock, ROUNDS clocks total
// ST_DONE | plaintext presented, waiting for out_ready
module tea_decrypt_core
  import tea_decrypt_core_pkg::*;
#(
  parameter int          ROUNDS = TEA_ROUNDS,
  parameter logic [31:0] DELTA  = TEA_DELTA
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         busy
);

  localparam int          CNT_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);
  localparam logic [63:0] SUM_PROD = 64'(DELTA) * 64'(ROUNDS);
  localparam logic [31:0] SUM_INIT =
    (ROUNDS == TEA_ROUNDS && DELTA == TEA_DELTA) ? TEA_SUM_INIT_DEC : SUM_PROD[31:0];

  state_t state, state_nxt;

  logic [31:0]      v0, v1, sum;
  logic [127:0]     key_q;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      out_data_q;
  logic             load, step;
  logic [31:0]      f_v1, f_v0, v1_nxt, v0_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // v0 update consumes the freshly computed v1 within the same clock.
  functionF F_v1 (.x(v0),     .kl(key_q[63:32]),  .kr(key_q[31:0]),  .s(sum), .f(f_v1));
  assign v1_nxt = v1 - f_v1;
  functionF F_v0 (.x(v1_nxt), .kl(key_q[127:96]), .kr(key_q[95:64]), .s(sum), .f(f_v0));
  assign v0_nxt = v0 - f_v0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0         <= '0;
      v1         <= '0;
      sum        <= '0;
      key_q      <= '0;
      cnt        <= '0;
      out_data_q <= '0;
    end else if (load) begin
      v0    <= in_data[63:32];
      v1    <= in_data[31:0];
      key_q <= key;
      sum   <= SUM_INIT;
      cnt   <= '0;
    end else if (step) begin
      v0  <= v0_nxt;
      v1  <= v1_nxt;
      sum <= sum - DELTA;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) out_data_q <= {v0_nxt, v1_nxt};
    end
  end

  assign out_data = out_data_q;

  // The schedule must unwind to zero on the last round.
  a_sum_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_RUN && cnt == LAST) |-> (sum == DELTA));

endmodule
